// File: rtl/up_req_engine.sv
// Upstream request engine: turns single-cycle accessor requests into handshaked TX descriptors
// and matches RX completions against the single outstanding read, issuing one ack per request.
module up_req_engine #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             user_clk,
    input  logic             user_reset,
    input  logic             up_read,
    input  logic             up_write,
    input  logic [4:0]       up_txtag,
    input  logic [63:0]      up_address,
    input  logic [63:0]      up_writedata,
    output logic             up_wait,
    output logic             up_ack,
    output logic [4:0]       up_rxtag,
    output logic [63:0]      up_readdata,
    output logic [2:0]       up_err,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_is_write,
    output logic [4:0]       tx_tag,
    output logic [63:0]      tx_address,
    output logic [63:0]      tx_data,
    input  logic             cpl_valid,
    input  logic [4:0]       cpl_tag,
    input  logic [2:0]       cpl_status,
    input  logic [63:0]      cpl_data,
    output logic [CNT_W-1:0] stray_count,
    output logic [CNT_W-1:0] drop_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TX       = 2'd1,
        S_WAIT_CPL = 2'd2,
        S_RESP     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_wait;
    logic [31:0]       r_tmo;
    logic              r_is_write;
    logic [4:0]        r_tag;
    logic [63:0]       r_addr;
    logic [63:0]       r_data;
    logic [4:0]        r_rxtag;
    logic [63:0]       r_rdata;
    logic [2:0]        r_err;
    logic [CNT_W-1:0]  r_stray;
    logic [CNT_W-1:0]  r_drop;

    logic              w_req;
    logic              w_match;
    logic              w_expire;
    logic              w_load;
    logic [2:0]        w_err;
    logic [63:0]       w_rdata;

    assign w_req    = up_read | up_write;
    assign w_match  = (r_state == S_WAIT_CPL) && cpl_valid && (cpl_tag == r_tag);
    assign w_expire = (r_state == S_WAIT_CPL) && (r_tmo == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_err   = '0;
        w_rdata = r_rdata;
        case (r_state)
            S_IDLE: if (w_req) w_next = S_TX;
            S_TX: begin
                if (tx_ready) begin
                    if (r_is_write) begin
                        w_next = S_RESP;
                        w_load = 1'b1;
                    end else begin
                        w_next = S_WAIT_CPL;
                    end
                end
            end
            S_WAIT_CPL: begin
                // a completion arriving in the expiry cycle takes priority over the timeout
                if (w_match) begin
                    w_next = S_RESP;
                    w_load = 1'b1;
                    case (cpl_status)
                        3'b000:  w_err = 3'b000;
                        3'b001:  w_err = 3'b001;
                        3'b100:  w_err = 3'b010;
                        default: w_err = 3'b011;
                    endcase
                    w_rdata = (cpl_status == 3'b000) ? cpl_data : '1;
                end else if (w_expire) begin
                    w_next  = S_RESP;
                    w_load  = 1'b1;
                    w_err   = 3'b100;
                    w_rdata = '1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            r_state    <= S_IDLE;
            r_wait     <= 1'b0;
            r_tmo      <= '0;
            r_is_write <= 1'b0;
            r_tag      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_rxtag    <= '0;
            r_rdata    <= '0;
            r_err      <= '0;
            r_stray    <= '0;
            r_drop     <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_next != S_IDLE);
            if (r_state == S_IDLE && w_req) begin
                r_is_write <= ~up_read;
                r_tag      <= up_txtag;
                r_addr     <= up_address;
                r_data     <= up_writedata;
            end
            if (r_state == S_TX)
                r_tmo <= '0;
            else if (r_state == S_WAIT_CPL)
                r_tmo <= r_tmo + 32'd1;
            if (w_load) begin
                r_rxtag <= r_tag;
                r_err   <= w_err;
                r_rdata <= w_rdata;
            end
            if (w_req && r_state != S_IDLE && r_drop != '1)
                r_drop <= r_drop + 1'b1;
            if (cpl_valid && !w_match && r_stray != '1)
                r_stray <= r_stray + 1'b1;
        end
    end

    assign up_wait     = r_wait;
    assign up_ack      = (r_state == S_RESP);
    assign up_rxtag    = r_rxtag;
    assign up_readdata = r_rdata;
    assign up_err      = r_err;
    assign tx_valid    = (r_state == S_TX);
    assign tx_is_write = r_is_write;
    assign tx_tag      = r_tag;
    assign tx_address  = r_addr;
    assign tx_data     = r_data;
    assign stray_count = r_stray;
    assign drop_count  = r_drop;

endmodule

// File: doc/up_req_engine.md
# up_req_engine

Converts the single-cycle upstream memory requests issued by the BAR-side accessor into handshaked request descriptors for the TLP transmit builder. It also matches returning completions from the RX parser against the outstanding read tag and hands back one acknowledge per accepted request. It sits between the accessor's up_* port and the PCIe TX/RX datapaths. One request is in flight at a time; writes are posted, reads wait for a completion or time out.

## Interface
- TIMEOUT_CYCLES, 50000, cycles to wait for a read completion after TX handshake (legal 2..2^32-1)
- CNT_W, 8, width of saturating diagnostic counters
- user_clk  in  1  clock; all logic rising-edge
- user_reset  in  1  reset; asynchronous, active-high
- up_read  in  1  single-cycle read request pulse
- up_write  in  1  single-cycle write request pulse
- up_txtag  in  5  request tag
- up_address  in  64  request address
- up_writedata  in  64  write data
- up_wait  out  1  engine busy; requests seen while high are dropped
- up_ack  out  1  one-cycle completion pulse for the accepted request
- up_rxtag  out  5  tag of acknowledged request
- up_readdata  out  64  read data (valid with up_ack)
- up_err  out  3  status with up_ack
- tx_valid  out  1  descriptor valid
- tx_ready  in  1  TX builder accepts descriptor
- tx_is_write  out  1  1 = MWr, 0 = MRd
- tx_tag, tx_address, tx_data  out  5/64/64  descriptor fields, stable while tx_valid
- cpl_valid  in  1  completion strobe from RX parser
- cpl_tag  in  5  completion tag
- cpl_status  in  3  PCIe completion status
- cpl_data  in  64  completion payload
- stray_count  out  CNT_W  completions not matching an outstanding read (saturating)
- drop_count  out  CNT_W  requests dropped while busy (saturating)

## Operation
- States: IDLE, TX, WAIT_CPL, RESP. up_wait is registered and is 1 in every state except IDLE.
- IDLE: if up_read or up_write, latch tag, address, data, and direction, then go to TX. If both are high, the request is a read and the write is ignored.
- TX: hold tx_valid=1 with latched fields until tx_ready. On the handshake, a write goes to RESP and a read goes to WAIT_CPL with the timeout counter cleared.
- WAIT_CPL: counter increments each cycle.
  - cpl_valid with cpl_tag equal to the latched tag captures status and data, then goes to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 with no matching completion, up_err becomes 3'b100 and up_readdata all ones; go to RESP.
  - A matching completion in the expiry cycle wins over the timeout.
- RESP: up_ack=1 for exactly one cycle with up_rxtag = latched tag, then go to IDLE.
- Error mapping:
  - cpl_status 000 (SC) gives up_err 000 with data = cpl_data.
  - 001 (UR) gives 001; 100 (CA) gives 010; any other status gives 011.
  - All non-SC cases force up_readdata to all ones. Writes always ack with err 000.
- up_readdata/up_err/up_rxtag hold their value after ack until the next ack.
- Drops: up_read|up_write while state≠IDLE. The request is discarded, no ack is issued, and drop_count increments (saturating at all ones).
- Strays: cpl_valid in any state except a tag match in WAIT_CPL. The completion is discarded and stray_count increments (saturating). This includes late completions after a timeout.

## Timing
- Reset (async assert): state IDLE; every output 0, including up_readdata, up_err, tx_* fields, and both counters. The timeout counter is cleared.
- Reset mid-operation abandons the request with no ack. Any later completion for it counts as a stray.
- Request sampled in cycle 0 gives tx_valid=1 and up_wait=1 in cycle 1.
- TX handshake in cycle N:
  - Write: up_ack in cycle N+1.
  - Read: WAIT_CPL from cycle N+1.
- Matching completion in cycle M gives up_ack in cycle M+1, carrying the cycle-M data/status.
- No completion: expiry in cycle N+TIMEOUT_CYCLES, up_ack in N+TIMEOUT_CYCLES+1.
- up_wait returns to 0 in the cycle after up_ack. A request coincident with up_ack is dropped. A request in the cycle after up_ack is accepted.
- Minimum back-to-back write spacing with tx_ready tied high is 3 cycles.

## Test plan
- Write, tx_ready=1: up_write tag 5'h3, addr 0x1000, data 0xA5A5 → tx_valid cycle 1 with is_write=1, tag 3, data 0xA5A5; up_ack cycle 2, err 000, rxtag 3.
- Read with TX backpressure: up_read tag 7, tx_ready low 4 cycles, then cpl_valid tag 7 status 000 data 0x1122334455667788 → fields stable during the stall; up_ack one cycle later with that data and err 000.
- Read timeout (TIMEOUT_CYCLES=16): no completion → up_ack exactly 17 cycles after the handshake, err 100, data all ones. A completion tag 7 two cycles later → stray_count=1, no ack.
- Error completions: statuses 001, 100, 010 on three reads → err 001, 010, 011 respectively, data all ones each time.
- Busy drop and collisions:
  - up_write during WAIT_CPL → drop_count=1.
  - up_read and up_write together in IDLE → a single MRd descriptor.
  - Wrong-tag completion during WAIT_CPL → stray_count increments and the engine stays waiting.
- Async reset asserted in WAIT_CPL: outputs 0 immediately, no ack. The request after reset release is served normally, and 256 strays saturate stray_count at 255.
